// File: rtl/issue_div_arbiter_pkg.sv
// Shared types and constants for the divide-unit arbiter slice.
package issue_div_arbiter_pkg;

    // Physical register identifier width used by the wakeup network.
    localparam int PREG_ID_W = 7;

    // Latency of the shared integer divider, start to result.
    localparam int FU_DIV_LATENCY      = 32;
    localparam int DIV_LATENCY_DEFAULT = FU_DIV_LATENCY;

    // Destination descriptor carried by a divide: {reg_id, valid}.
    typedef struct packed {
        logic [PREG_ID_W-1:0] reg_id;
        logic                 valid;
    } phys_reg;

    // Occupancy of the shared divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } divState_t;

    // Wakeup tag as broadcast: nothing when not firing, and a zero
    // reg_id whenever the destination is not a real register.
    function automatic phys_reg wakeup_tag(input phys_reg dest, input logic fire);
        phys_reg tag;
        tag = '0;
        if (fire && dest.valid) begin
            tag.reg_id = dest.reg_id;
            tag.valid  = 1'b1;
        end
        return tag;
    endfunction

endpackage

// File: rtl/issue_div_arbiter_rr_arbiter.sv
// Round-robin picker: combinational first-request-at-or-after-pointer
// search with wrap, plus the rotating priority pointer.
module rr_arbiter
    import issue_div_arbiter_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PTR_W     = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [NUM_LANES-1:0] req_i,
    output logic [NUM_LANES-1:0] grant_o,
    output logic [PTR_W-1:0]     grantIdx_o,
    output logic                 anyGrant_o
);

    logic [PTR_W-1:0] rrPtr_q;
    logic [PTR_W-1:0] rrPtr_d;

    // Lane index base+off, wrapped into [0, NUM_LANES) so that lane counts
    // that are not a power of two never produce an out-of-range index.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_LANES) begin
            sum = sum - NUM_LANES;
        end
        return PTR_W'(sum);
    endfunction

    // Priority search: walking offsets from far to near leaves the nearest
    // requesting lane (smallest offset from the pointer) as the winner.
    always_comb begin
        grant_o    = '0;
        grantIdx_o = '0;
        anyGrant_o = 1'b0;
        for (int off = NUM_LANES - 1; off >= 0; off--) begin
            if (req_i[wrap_add(rrPtr_q, off)]) begin
                grantIdx_o = wrap_add(rrPtr_q, off);
                anyGrant_o = 1'b1;
            end
        end
        if (anyGrant_o) begin
            grant_o[grantIdx_o] = 1'b1;
        end
    end

    // Lane after the winner, wrapping explicitly at the last lane.
    always_comb begin
        rrPtr_d = '0;
        if (grantIdx_o != PTR_W'(NUM_LANES - 1)) begin
            rrPtr_d = grantIdx_o + 1'b1;
        end
    end

    // Pointer advances only when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            rrPtr_q <= '0;
        end else if (en_i) begin
            rrPtr_q <= rrPtr_d;
        end
    end

endmodule

// File: rtl/issue_div_arbiter.sv
// Shares one non-pipelined divider among the issue lanes: round-robin
// grant, occupancy tracking, writeback negotiation and wakeup broadcast.
module issue_div_arbiter
    import issue_div_arbiter_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
    parameter int CNT_W       = $clog2(DIV_LATENCY)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic    [NUM_LANES-1:0]       req_i,
    input  logic    [NUM_LANES-1:0]       laneActive_i,
    input  phys_reg [NUM_LANES-1:0]       reqDest_i,
    input  logic                          wbGrant_i,
    output logic    [NUM_LANES-1:0]       grant_o,
    output logic                          divStart_o,
    output logic                          busy_o,
    output logic                          wbReq_o,
    output phys_reg                       rsrTag_o
);

    localparam int PTR_W = $clog2(NUM_LANES);

    divState_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    phys_reg          destQ_q, destQ_d;
    logic             divStart_q, divStart_d;

    logic                 clear;
    logic [NUM_LANES-1:0] arbReq;
    logic [PTR_W-1:0]     grantIdx;
    logic                 anyGrant;
    logic                 wbFire;

    // Flush and reset are interchangeable here and dominate everything else.
    assign clear = reset | flush_i;

    // Only an idle, un-flushed divider offers itself to the lanes; requests
    // seen while busy are simply dropped and retried by the lane.
    assign arbReq = (state_q == IDLE && !clear) ? (req_i & laneActive_i) : '0;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_rr_arbiter (
        .clk        (clk),
        .clear_i    (clear),
        .en_i       (anyGrant),
        .req_i      (arbReq),
        .grant_o    (grant_o),
        .grantIdx_o (grantIdx),
        .anyGrant_o (anyGrant)
    );

    // Writeback completes only in WB; a stray wbGrant_i elsewhere is ignored.
    assign wbFire = (state_q == WB) && wbGrant_i && !clear;

    // Next-state logic for the occupancy FSM, latency counter and destination.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        destQ_d    = destQ_q;
        divStart_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyGrant) begin
                    state_d    = EXEC;
                    cnt_d      = CNT_W'(DIV_LATENCY - 1);
                    destQ_d    = reqDest_i[grantIdx];
                    divStart_d = 1'b1;
                end
            end
            EXEC: begin
                // Leaving on the decrement that reaches zero puts the first
                // WB cycle exactly DIV_LATENCY cycles after the grant.
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = WB;
                end
            end
            WB: begin
                if (wbFire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; a flush abandons any divide in flight.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            destQ_q    <= '0;
            divStart_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            destQ_q    <= destQ_d;
            divStart_q <= divStart_d;
        end
    end

    // Combinational status outputs are forced low in a flush cycle.
    always_comb begin
        busy_o   = !clear && (state_q != IDLE);
        wbReq_o  = !clear && (state_q == WB);
        rsrTag_o = wakeup_tag(destQ_q, wbFire);
    end

    assign divStart_o = divStart_q;

endmodule

// File: tb/tb_issue_div_arbiter.sv
// Scoreboard bench for issue_div_arbiter: a time-based reference model
// queues the expected outputs of every cycle; a negedge monitor compares.
module tb_issue_div_arbiter;
    import issue_div_arbiter_pkg::*;

    localparam int N = 4;
    localparam int L = 4;

    logic             clk;
    logic             reset;
    logic             flush_i;
    logic [N-1:0]     req_i;
    logic [N-1:0]     laneActive_i;
    phys_reg [N-1:0]  reqDest_i;
    logic             wbGrant_i;
    logic [N-1:0]     grant_o;
    logic             divStart_o;
    logic             busy_o;
    logic             wbReq_o;
    phys_reg          rsrTag_o;

    issue_div_arbiter #(
        .NUM_LANES   (N),
        .DIV_LATENCY (L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .req_i        (req_i),
        .laneActive_i (laneActive_i),
        .reqDest_i    (reqDest_i),
        .wbGrant_i    (wbGrant_i),
        .grant_o      (grant_o),
        .divStart_o   (divStart_o),
        .busy_o       (busy_o),
        .wbReq_o      (wbReq_o),
        .rsrTag_o     (rsrTag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] grant;
        logic         divStart;
        logic         busy;
        logic         wbReq;
        logic [7:0]   tag;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_cyc  = 0;

    // Reference model: a divide is "outstanding" from its grant until its
    // tag is broadcast; its result is ready L cycles after the grant.
    bit         m_outst     = 0;
    int         m_gcyc      = 0;
    logic [7:0] m_dest      = '0;
    int         m_ptr       = 0;
    bit         m_prevGrant = 0;
    int         m_cyc       = 0;

    // Monitor-side observation helpers for the directed scenarios.
    bit   log_en = 0;
    bit   cnt_en = 0;
    int   glane[$];
    int   gcyc[$];
    int   wb_hi = 0;
    int   tags  = 0;
    exp_t me;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, mon_cyc, act, exp);
        end
    endtask

    task automatic model_step();
        exp_t e;
        int   lane;
        bit   was_outst;
        e = '0;
        e.divStart = m_prevGrant;
        if (reset || flush_i) begin
            m_outst     = 0;
            m_ptr       = 0;
            m_prevGrant = 0;
        end else begin
            was_outst = m_outst;
            e.busy    = was_outst;
            e.wbReq   = was_outst && (m_cyc >= m_gcyc + L);
            if (e.wbReq && wbGrant_i) begin
                e.tag   = m_dest[0] ? m_dest : 8'h00;
                m_outst = 0;
            end
            lane = -1;
            if (!was_outst) begin
                for (int k = 0; k < N; k++) begin
                    int l;
                    l = (m_ptr + k) % N;
                    if (lane < 0 && req_i[l] && laneActive_i[l]) lane = l;
                end
            end
            if (lane >= 0) begin
                e.grant[lane] = 1'b1;
                m_outst = 1;
                m_gcyc  = m_cyc;
                m_dest  = reqDest_i[lane];
                m_ptr   = (lane + 1) % N;
            end
            m_prevGrant = (lane >= 0);
        end
        m_cyc++;
        expq.push_back(e);
    endtask

    task automatic step(input logic r, input logic f, input logic [N-1:0] rq,
                        input logic [N-1:0] act, input logic wg);
        reset        = r;
        flush_i      = f;
        req_i        = rq;
        laneActive_i = act;
        wbGrant_i    = wg;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_dest();
        for (int l = 0; l < N; l++) reqDest_i[l] = phys_reg'($urandom_range(0, 255));
    endtask

    // Monitor: compare the DUT against the queued expectation mid-cycle.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            chk("grant_o",    32'(grant_o),    32'(me.grant));
            chk("divStart_o", 32'(divStart_o), 32'(me.divStart));
            chk("busy_o",     32'(busy_o),     32'(me.busy));
            chk("wbReq_o",    32'(wbReq_o),    32'(me.wbReq));
            chk("rsrTag_o",   32'(rsrTag_o),   32'(me.tag));
            if (log_en && grant_o != '0) begin
                for (int l = 0; l < N; l++) if (grant_o[l]) glane.push_back(l);
                gcyc.push_back(mon_cyc);
            end
            if (cnt_en) begin
                if (wbReq_o) wb_hi++;
                if (rsrTag_o.valid) tags++;
            end
            mon_cyc++;
        end
    end

    initial begin
        reset        = 1'b1;
        flush_i      = 1'b0;
        req_i        = '0;
        laneActive_i = '1;
        wbGrant_i    = 1'b0;
        reqDest_i    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state, then idle with no requests.
        repeat (3) step(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0);
        repeat (10) step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0);

        // Single request from lane 2 with destination {17,1}, writeback always granted.
        reqDest_i[2] = {7'd17, 1'b1};
        cnt_en = 1; tags = 0;
        step(1'b0, 1'b0, 4'b0100, 4'b1111, 1'b1);
        repeat (8) step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
        cnt_en = 0;
        chk("single_tag_count", 32'(tags), 32'd1);

        // Fairness: all lanes requesting continuously from a fresh pointer.
        step(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);
        log_en = 1;
        repeat (5 * (L + 1) + 1) step(1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1);
        log_en = 0;
        chk("fair_grant_count_ok", 32'(glane.size() >= 5), 32'd1);
        if (glane.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("fair_lane", 32'(glane[i]), 32'(i % N));
            for (int i = 1; i < 5; i++) chk("fair_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'(L + 1));
        end

        // Writeback stall: three refused cycles in WB, then granted.
        step(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0);
        reqDest_i[1] = {7'd42, 1'b1};
        cnt_en = 1; wb_hi = 0; tags = 0;
        step(1'b0, 1'b0, 4'b0010, 4'b1111, 1'b0);
        repeat (L - 1) step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0);
        repeat (3) step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
        repeat (3) step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0);
        cnt_en = 0;
        chk("stall_wbreq_cycles", 32'(wb_hi), 32'd4);
        chk("stall_tag_count", 32'(tags), 32'd1);

        // Flush in EXEC with two cycles of count left: no tag ever follows.
        step(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);
        reqDest_i[0] = {7'd9, 1'b1};
        cnt_en = 1; tags = 0;
        step(1'b0, 1'b0, 4'b0001, 4'b1111, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
        step(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1);
        repeat (10) step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);
        cnt_en = 0;
        chk("flush_no_tag", 32'(tags), 32'd0);

        // Flush with a request in the same idle cycle, then an inactive lane.
        step(1'b0, 1'b1, 4'b0001, 4'b1111, 1'b1);
        repeat (8) step(1'b0, 1'b0, 4'b0100, 4'b1011, 1'b1);

        // Invalid destination still completes the handshake with a zero tag.
        reqDest_i[3] = {7'd55, 1'b0};
        step(1'b0, 1'b0, 4'b1000, 4'b1111, 1'b1);
        repeat (L + 2) step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] rq, act;
            logic         wg, f, r;
            rand_dest();
            rq  = N'($urandom);
            act = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            wg  = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 63) == 0);
            r   = ($urandom_range(0, 199) == 0);
            step(r, f, rq, act, wg);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_div_arbiter.md
# issue_div_arbiter

Shares one non-pipelined integer divide unit among the complex issue lanes. The block arbitrates same-cycle divide requests round-robin and tracks the divider's occupancy with a latency counter. It raises `busy_o` so lanes mask divide entries out of their request vectors, negotiates the shared writeback port, and broadcasts the destination tag for wakeup. It sits beside the issue lanes' select logic and the RSR wakeup path, and is flushed with the issue queue.

## Interface
- `NUM_LANES`, 4: number of requesting issue lanes (≥2).
- `DIV_LATENCY`, 32: divider cycles from start to result (≥2).
- `CNT_W`, $clog2(DIV_LATENCY): counter width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush_i` in 1: pipeline flush. Same effect as `reset` on this block.
- `req_i` in NUM_LANES: lane i selected a divide this cycle.
- `laneActive_i` in NUM_LANES: lane enable. An inactive lane's request is ignored.
- `reqDest_i` in NUM_LANES × phys_reg: destination {reg_id, valid} per lane.
- `wbGrant_i` in 1: writeback port granted to the divider this cycle.
- `grant_o` out NUM_LANES: one-hot grant, combinational.
- `divStart_o` out 1: registered start pulse to the divide unit.
- `busy_o` out 1: divider occupied. Lanes must not request while it is high.
- `wbReq_o` out 1: result ready, requesting the writeback port.
- `rsrTag_o` out phys_reg: wakeup tag. `reg_id` is 0 whenever `valid` is 0.

## Operation
- FSM states:
  - IDLE: free.
  - EXEC: divide in progress.
  - WB: result held, waiting for the writeback port.
- Effective request is `req_i & laneActive_i`.
- In IDLE with no flush, `grant_o` selects the first effective request at or after `rrPtr`, searching upward with wrap. All other states give `grant_o`=0.
- On a grant:
  - capture `reqDest_i[granted]` into `destQ`;
  - load `cnt` = DIV_LATENCY-1;
  - `rrPtr` becomes granted+1 mod NUM_LANES;
  - next state EXEC;
  - `divStart_o`=1 for the next cycle only.
- EXEC: `cnt` decrements by 1 each cycle. When `cnt`==0, next state is WB.
- WB:
  - `wbReq_o`=1.
  - If `wbGrant_i`=1: `rsrTag_o`={destQ.reg_id, destQ.valid} this cycle, combinational from state and `wbGrant_i`, and next state IDLE.
  - Otherwise remain in WB with the tag held off.
- A destination with valid=0 still completes the handshake. `rsrTag_o.valid` stays 0 in that case.
- `busy_o` = (state≠IDLE).
- Requests arriving while busy get no grant and are not queued; the lane retries.
- `wbGrant_i` outside WB is ignored.
- `reset` or `flush_i` (synchronous) sets:
  - state IDLE, `cnt`=0, `destQ`=0;
  - `rrPtr`=0, `divStart_o`=0;
  - all combinational outputs are 0 in the flush cycle itself.
- Flush in EXEC or WB abandons the divide. No tag is ever broadcast for it.

## Timing
- Reset values: `grant_o`=0, `divStart_o`=0, `busy_o`=0, `wbReq_o`=0, `rsrTag_o`=0.
- Grant in cycle T:
  - `divStart_o` and `busy_o` high at T+1;
  - `wbReq_o` first high at T+DIV_LATENCY;
  - earliest tag and return to IDLE at T+DIV_LATENCY, so the next grant comes no earlier than T+DIV_LATENCY+1.
- Every cycle of `wbGrant_i`=0 in WB adds one cycle.
- Flush has priority over a grant, count, or handshake in the same cycle.
- The round-robin pointer is never left pointing at an out-of-range lane.

## Structure
- The shared package holds:
  - `phys_reg`;
  - the FSM enum `divState_t` {IDLE, EXEC, WB};
  - `DIV_LATENCY` default, taken from the existing FU latency constant.
- One sub-module: `rr_arbiter` (NUM_LANES, combinational masked-priority pick plus the `rrPtr` register with enable and synchronous clear). The FSM and counter stay in the top.

## Test plan
- Reset then idle: all outputs 0; `req_i`=4'b0000 for 10 cycles → `busy_o`=0.
- Single request:
  - stimulus: lane 2 requests at T=5 with dest {17,1}, DIV_LATENCY=4, `wbGrant_i` tied to 1;
  - expected: `grant_o`=4'b0100 at 5, `divStart_o` at 6, `wbReq_o` and `rsrTag_o`={17,1} at 9, `busy_o` low at 10.
- Fairness: all four lanes request continuously → grants go 0,1,2,3,0, each separated by DIV_LATENCY+1 cycles.
- Writeback stall: `wbGrant_i` held at 0 for 3 cycles in WB → `wbReq_o` high for 4 cycles, and the tag appears only in the granted cycle.
- Flush mid-EXEC: at `cnt`=2 → next cycle `busy_o`=0, and no `rsrTag_o` ever for that divide.
- Simultaneous flush and request:
  - flush and a request in the same IDLE cycle → `grant_o`=0;
  - `laneActive_i`=4'b1011 with only lane 2 requesting → never granted.
